// File: rtl/apb_arbiter.sv
// apb_arbiter: two-requester round-robin arbiter driving a single APB master port,
// with wait-state timeout and one-cycle completion pulses back to the requesters.
module apb_arbiter #(
   parameter int TIMEOUT = 15
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        REQ0,
   input  logic        REQ1,
   input  logic [31:0] ADDR0,
   input  logic [31:0] ADDR1,
   input  logic        WRITE0,
   input  logic        WRITE1,
   input  logic [31:0] WDATA0,
   input  logic [31:0] WDATA1,
   output logic        ACK0,
   output logic        ACK1,
   output logic [31:0] RDATA0,
   output logic [31:0] RDATA1,
   output logic        ERR0,
   output logic        ERR1,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [31:0] PADDR,
   output logic [31:0] PWDATA,
   input  logic        PREADY,
   input  logic        PSLVERR,
   input  logic [31:0] PRDATA,
   output logic        BUSY,
   output logic        GNT_ID
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   state_t      r_state;
   logic [7:0]  r_cnt;
   logic        r_last;
   logic        r_psel, r_penable, r_pwrite, r_gnt;
   logic        r_ack0, r_ack1, r_err0, r_err1;
   logic [31:0] r_paddr, r_pwdata, r_rdata0, r_rdata1;
   logic        w_req0, w_req1, w_win, w_tmo, w_done, w_err;
   logic [31:0] w_rd;
   // a requester being acknowledged this cycle is still holding its old request
   assign w_req0 = REQ0 & ~r_ack0;
   assign w_req1 = REQ1 & ~r_ack1;
   assign w_win  = (w_req0 & w_req1) ? ~r_last : w_req1;
   assign w_tmo  = (r_cnt == 8'(TIMEOUT - 1));
   assign w_done = PREADY | w_tmo;
   assign w_err  = PREADY ? PSLVERR : 1'b1;
   assign w_rd   = (PREADY & ~r_pwrite) ? PRDATA : '0;
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_last    <= 1'b1;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b0;
         r_gnt     <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_ack0    <= 1'b0;
         r_ack1    <= 1'b0;
         r_err0    <= 1'b0;
         r_err1    <= 1'b0;
         r_rdata0  <= '0;
         r_rdata1  <= '0;
      end else begin
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_err0   <= 1'b0;
         r_err1   <= 1'b0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
         case (r_state)
            IDLE: if (w_req0 | w_req1) begin
               r_state  <= SETUP;
               r_psel   <= 1'b1;
               r_gnt    <= w_win;
               r_last   <= w_win;
               r_paddr  <= w_win ? ADDR1 : ADDR0;
               r_pwrite <= w_win ? WRITE1 : WRITE0;
               r_pwdata <= w_win ? WDATA1 : WDATA0;
               r_cnt    <= '0;
            end
            SETUP: begin
               r_state   <= ACCESS;
               r_penable <= 1'b1;
            end
            ACCESS: if (w_done) begin
               r_state   <= IDLE;
               r_psel    <= 1'b0;
               r_penable <= 1'b0;
               r_ack0    <= ~r_gnt;
               r_ack1    <= r_gnt;
               r_err0    <= ~r_gnt & w_err;
               r_err1    <= r_gnt & w_err;
               r_rdata0  <= r_gnt ? '0 : w_rd;
               r_rdata1  <= r_gnt ? w_rd : '0;
            end else begin
               r_cnt <= r_cnt + 8'd1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign PSEL    = r_psel;
   assign PENABLE = r_penable;
   assign PWRITE  = r_pwrite;
   assign PADDR   = r_paddr;
   assign PWDATA  = r_pwdata;
   assign BUSY    = r_psel;
   assign GNT_ID  = r_gnt;
   assign ACK0    = r_ack0;
   assign ACK1    = r_ack1;
   assign ERR0    = r_err0;
   assign ERR1    = r_err1;
   assign RDATA0  = r_rdata0;
   assign RDATA1  = r_rdata1;
endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 15, number of ACCESS cycles with PREADY low before forced termination (range 1..255).
REQ-002 HCLK  input  1  single clock; all state changes on rising edge.
REQ-003 HRESETn  input  1  asynchronous, active-low reset.
REQ-004 REQ0, REQ1  input  1 each  transfer request from requester n; level, held until ACKn.
REQ-005 ADDR0, ADDR1  input  32 each  transfer address from requester n.
REQ-006 WRITE0, WRITE1  input  1 each  1 = write, 0 = read.
REQ-007 WDATA0, WDATA1  input  32 each  write data from requester n.
REQ-008 ACK0, ACK1  output  1 each  one-cycle completion pulse to requester n.
REQ-009 RDATA0, RDATA1  output  32 each  read data to requester n, valid while ACKn high.
REQ-010 ERR0, ERR1  output  1 each  error flag to requester n, valid while ACKn high.
REQ-011 PSEL, PENABLE, PWRITE  output  1 each  APB master controls.
REQ-012 PADDR, PWDATA  output  32 each  APB address and write data.
REQ-013 PREADY, PSLVERR  input  1 each  APB slave ready and error.
REQ-014 PRDATA  input  32  APB read data.
REQ-015 BUSY  output  1  high in SETUP and ACCESS; GNT_ID  output  1  requester currently owning the APB bus.

Function
REQ-016 FSM states: IDLE, SETUP, ACCESS; PSEL=1 in SETUP and ACCESS, PENABLE=1 only in ACCESS.
REQ-017 IDLE: if any unmasked REQn sampled high, register winner's ADDR/WRITE/WDATA into PADDR/PWRITE/PWDATA, set GNT_ID, go SETUP; else stay IDLE.
REQ-018 Masking: a requester whose ACKn is high in the current cycle is excluded from arbitration in that cycle.
REQ-019 Round robin: both requesting -> grant the requester not granted last; after reset requester 0 wins the first tie.
REQ-020 Single requester: granted regardless of pointer; pointer updates to the granted ID on every grant.
REQ-021 SETUP -> ACCESS unconditionally after one cycle.
REQ-022 ACCESS, PREADY=1: go IDLE; next cycle ACK[GNT_ID]=1 for exactly one cycle, ERR=PSLVERR as sampled, RDATA=PRDATA as sampled if read, else 0.
REQ-023 ACCESS, PREADY=0: increment wait counter; counter cleared on entry to SETUP.
REQ-024 Wait counter reaching TIMEOUT with PREADY still 0: go IDLE; next cycle ACK[GNT_ID]=1, ERR=1, RDATA=0.
REQ-025 PREADY=1 in the same cycle the counter reaches TIMEOUT: normal completion (REQ-022) takes priority.
REQ-026 PADDR, PWRITE, PWDATA stable from SETUP through final ACCESS cycle; REQn/payload changes during a transfer are ignored.
REQ-027 Latency, zero wait states: REQn sampled in IDLE at edge k -> SETUP cycle k+1, ACCESS k+2, ACKn in cycle k+3.
REQ-028 ACK0 and ACK1 never high in the same cycle; RDATAn/ERRn = 0 when ACKn low.
REQ-029 Requester semantics: each ACKn retires one transfer; requester drops REQn or presents the next payload at the edge where ACKn is sampled.

Reset
REQ-030 HRESETn low asynchronously forces IDLE: PSEL, PENABLE, PWRITE, BUSY, GNT_ID, ACK0/1, ERR0/1 = 0; PADDR, PWDATA, RDATA0/1 = 0; wait counter = 0; pointer selects requester 0 for the next tie.
REQ-031 Reset mid-transfer aborts it with no ACK; after release, first arbitration occurs on the first rising edge with HRESETn high.

Verification
REQ-032 Single read: REQ0=1, ADDR0=32, WRITE0=0, PREADY=1, PRDATA=16 -> PSEL at k+1, PENABLE at k+2, ACK0=1 with RDATA0=16, ERR0=0 at k+3.
REQ-033 Contention: REQ0=REQ1=1 held, both writes (ADDR 0x10/0x20) -> grants 0,1,0,1 in order, PADDR alternates, one IDLE cycle between transfers.
REQ-034 Wait states: PREADY low for 3 ACCESS cycles then high, PSLVERR=1 -> PENABLE high 4 cycles, ACK with ERR=1, PADDR/PWDATA stable throughout.
REQ-035 Timeout: TIMEOUT=15, PREADY stuck 0 -> PSEL drops after 15 ACCESS cycles, ACK with ERR=1, RDATA=0; next request serviced normally.
REQ-036 Reset mid-ACCESS: HRESETn low during ACCESS -> PSEL/PENABLE/BUSY low immediately without clock, no ACK; REQ0=REQ1=1 after release -> requester 0 granted first.
